// File: rtl/seq_tx_pkg.sv
// Shared types and helpers for the serial pattern transmitter.
package seq_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP,
    ST_DONE
  } tx_state_e;

  localparam logic [3:0] REP_CONTINUOUS = 4'd0;

  function automatic logic len_legal(input int unsigned len, input int unsigned max_len);
    return (len >= 1) && (len <= max_len);
  endfunction

endpackage

// File: rtl/seq_bit_shifter.sv
// Loadable MSB-first shift register with a down-counting bit counter.
// The MSB of the shift register is the registered serial output bit.
module seq_bit_shifter #(
  parameter int   MAX_LEN    = 16,
  parameter int   CNT_W      = 5,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               load,
  input  logic               reload,
  input  logic               shift,
  input  logic [MAX_LEN-1:0] pat_in,
  input  logic [CNT_W-1:0]   len_in,
  output logic               cur_bit,
  output logic               last_bit
);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(MAX_LEN);

  logic [MAX_LEN-1:0] pat_q, sr;
  logic [CNT_W-1:0]   len_q, cnt;

  // Left-justify so bit len-1 of the pattern lands on the MSB.
  function automatic logic [MAX_LEN-1:0] align(input logic [MAX_LEN-1:0] p,
                                               input logic [CNT_W-1:0] l);
    return p << (FULL - l);
  endfunction

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      pat_q <= '0;
      len_q <= '0;
      sr    <= {MAX_LEN{IDLE_LEVEL}};
      cnt   <= '0;
    end else if (en) begin
      if (load) begin
        pat_q <= pat_in;
        len_q <= len_in;
        sr    <= align(pat_in, len_in);
        cnt   <= len_in;
      end else if (reload) begin
        sr  <= align(pat_q, len_q);
        cnt <= len_q;
      end else if (shift) begin
        sr  <= {sr[MAX_LEN-2:0], IDLE_LEVEL};
        cnt <= cnt - CNT_W'(1);
      end else begin
        // Not sending: park the line at the idle level.
        sr  <= {MAX_LEN{IDLE_LEVEL}};
        cnt <= '0;
      end
    end
  end

  assign cur_bit  = sr[MAX_LEN-1];
  assign last_bit = (cnt == CNT_W'(1));

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern transmitter: repeats a latched pattern MSB-first with
// an idle gap between passes; FSM, gap/pass counters and start handshake.
module seq_pattern_tx
  import seq_tx_pkg::*;
#(
  parameter int   MAX_LEN    = 16,
  parameter int   CNT_W      = 5,
  parameter int   GAP        = 2,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [MAX_LEN-1:0] pat_in,
  input  logic [CNT_W-1:0]   len_in,
  input  logic [3:0]         rep_in,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic               abort,
  output logic               tx_bit,
  output logic               tx_active,
  output logic               done,
  output logic               err,
  output logic [3:0]         pass_cnt
);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  tx_state_e   state, state_d;
  logic [3:0]  rep_q, pass_d, pass_nxt;
  logic [GW-1:0] gap_cnt, gap_d;
  logic        err_d, accept, len_ok;
  logic        sh_load, sh_reload, sh_shift, last_bit;

  assign start_ready = (state == ST_IDLE) && ena && !abort;
  assign accept      = start_valid && start_ready;
  assign len_ok      = len_legal(32'(len_in), MAX_LEN);
  assign pass_nxt    = pass_cnt + 4'd1;

  always_comb begin
    state_d   = state;
    pass_d    = pass_cnt;
    gap_d     = gap_cnt;
    err_d     = err;
    sh_load   = 1'b0;
    sh_reload = 1'b0;
    sh_shift  = 1'b0;
    unique case (state)
      ST_IDLE: if (accept) begin
        pass_d = '0;
        err_d  = !len_ok;
        if (len_ok) begin
          state_d = ST_SEND;
          sh_load = 1'b1;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_SEND: begin
        if (abort) state_d = ST_IDLE;
        else if (!last_bit) sh_shift = 1'b1;
        else begin
          // Edge that ends bit 0 of a pass.
          pass_d = pass_nxt;
          if (rep_q != REP_CONTINUOUS && pass_nxt == rep_q) state_d = ST_DONE;
          else if (GAP == 0) sh_reload = 1'b1;
          else begin
            state_d = ST_GAP;
            gap_d   = '0;
          end
        end
      end
      ST_GAP: begin
        if (abort) state_d = ST_IDLE;
        else if (gap_cnt == GW'(GAP - 1)) begin
          state_d   = ST_SEND;
          sh_reload = 1'b1;
        end else gap_d = gap_cnt + GW'(1);
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state    <= ST_IDLE;
      rep_q    <= '0;
      pass_cnt <= '0;
      gap_cnt  <= '0;
      err      <= 1'b0;
    end else if (ena) begin
      state    <= state_d;
      pass_cnt <= pass_d;
      gap_cnt  <= gap_d;
      err      <= err_d;
      if (accept) rep_q <= rep_in;
    end
  end

  seq_bit_shifter #(
    .MAX_LEN   (MAX_LEN),
    .CNT_W     (CNT_W),
    .IDLE_LEVEL(IDLE_LEVEL)
  ) u_shifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (ena),
    .load    (sh_load),
    .reload  (sh_reload),
    .shift   (sh_shift),
    .pat_in  (pat_in),
    .len_in  (len_in),
    .cur_bit (tx_bit),
    .last_bit(last_bit)
  );

  assign tx_active = (state == ST_SEND) || (state == ST_GAP);
  assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: expected serial streams are built per transfer
// from the pattern/length/repeat/gap rules and compared cycle by cycle.
module tb_seq_pattern_tx;
  localparam int   TB_GAP   = 2;
  localparam logic IDLE_LVL = 1'b0;

  logic        clk = 1'b0;
  logic        rst_n, ena, start_valid, abort;
  logic [15:0] pat_in;
  logic [4:0]  len_in;
  logic [3:0]  rep_in;
  logic        start_ready, tx_bit, tx_active, done, err;
  logic [3:0]  pass_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed { logic b; logic act; logic dn; } exp_t;

  seq_pattern_tx #(
    .MAX_LEN(16), .CNT_W(5), .GAP(TB_GAP), .IDLE_LEVEL(IDLE_LVL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .pat_in(pat_in), .len_in(len_in),
    .rep_in(rep_in), .start_valid(start_valid), .start_ready(start_ready),
    .abort(abort), .tx_bit(tx_bit), .tx_active(tx_active), .done(done),
    .err(err), .pass_cnt(pass_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One finite transfer (rep >= 1); optionally gates ena randomly mid-transfer.
  task automatic xfer(input logic [15:0] pat, input logic [4:0] len,
                      input logic [3:0] rep, input bit rnd_ena);
    exp_t q[$];
    exp_t cur;
    bit   legal, e;
    int   guard;
    legal = (len >= 1) && (len <= 16);
    if (legal)
      for (int p = 0; p < int'(rep); p++) begin
        for (int k = int'(len) - 1; k >= 0; k--) q.push_back('{pat[k], 1'b1, 1'b0});
        if (p < int'(rep) - 1)
          for (int g = 0; g < TB_GAP; g++) q.push_back('{IDLE_LVL, 1'b1, 1'b0});
      end
    q.push_back('{IDLE_LVL, 1'b0, 1'b1});

    @(negedge clk);
    ena = 1'b1; abort = 1'b0; start_valid = 1'b1;
    pat_in = pat; len_in = len; rep_in = rep;
    #1 chk("start_ready_idle", 32'(start_ready), 32'd1);
    @(negedge clk);
    start_valid = 1'b0;
    pat_in = 16'($urandom); len_in = 5'($urandom); rep_in = 4'($urandom);
    cur = q.pop_front();
    guard = 0;
    while (1) begin
      chk("tx_bit", 32'(tx_bit), 32'(cur.b));
      chk("tx_active", 32'(tx_active), 32'(cur.act));
      chk("done", 32'(done), 32'(cur.dn));
      chk("err", 32'(err), 32'(!legal));
      chk("start_ready_busy", 32'(start_ready), 32'd0);
      if (cur.dn) chk("pass_cnt_done", 32'(pass_cnt), legal ? 32'(rep) : 32'd0);
      e = rnd_ena ? ($urandom_range(0, 2) != 0) : 1'b1;
      ena = e;
      @(negedge clk);
      guard++;
      if (guard > 2000) begin
        chk("xfer_timeout", 32'(guard), 32'd0);
        break;
      end
      if (e) begin
        if (q.size() == 0) break;
        cur = q.pop_front();
      end
    end
    ena = 1'b1;
    chk("post_active", 32'(tx_active), 32'd0);
    chk("post_done", 32'(done), 32'd0);
    chk("post_tx_bit", 32'(tx_bit), 32'(IDLE_LVL));
    #1 chk("post_start_ready", 32'(start_ready), 32'd1);
  endtask

  initial begin
    int n, pl, idx, passes;
    logic [15:0] rp;
    logic [4:0]  rl;
    logic        eb;

    rst_n = 1'b1; ena = 1'b0; start_valid = 1'b0; abort = 1'b0;
    pat_in = '0; len_in = '0; rep_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_tx_bit", 32'(tx_bit), 32'(IDLE_LVL));
    chk("rst_active", 32'(tx_active), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_pass_cnt", 32'(pass_cnt), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("ready_ena0", 32'(start_ready), 32'd0);
    ena = 1'b1;
    #1 chk("ready_ena1", 32'(start_ready), 32'd1);

    // Directed transfers
    xfer(16'b100, 5'd3, 4'd1, 1'b0);
    xfer(16'b1011, 5'd4, 4'd2, 1'b0);
    xfer(16'hffff, 5'd0, 4'd1, 1'b0);
    xfer(16'b101, 5'd3, 4'd1, 1'b0);
    xfer(16'hffff, 5'd17, 4'd2, 1'b0);
    xfer(16'hbeef, 5'd16, 4'd1, 1'b0);
    xfer(16'b110, 5'd3, 4'd2, 1'b1);

    // abort together with start in IDLE blocks the accept
    @(negedge clk);
    start_valid = 1'b1; abort = 1'b1; pat_in = 16'b1; len_in = 5'd1; rep_in = 4'd1;
    #1 chk("ready_abort", 32'(start_ready), 32'd0);
    @(negedge clk);
    chk("abort_no_accept_active", 32'(tx_active), 32'd0);
    chk("abort_no_accept_done", 32'(done), 32'd0);
    start_valid = 1'b0; abort = 1'b0;

    // Continuous mode, abort after 20 completed passes
    rp = 16'b10; rl = 5'd2; pl = int'(rl) + TB_GAP;
    n  = 19 * pl + int'(rl) + 1;
    @(negedge clk);
    pat_in = rp; len_in = rl; rep_in = 4'd0; start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    for (int c = 1; c <= n; c++) begin
      idx    = (c - 1) % pl;
      eb     = (idx < int'(rl)) ? rp[int'(rl) - 1 - idx] : IDLE_LVL;
      passes = (c - 1 >= int'(rl)) ? ((c - 1 - int'(rl)) / pl + 1) : 0;
      chk("cont_tx_bit", 32'(tx_bit), 32'(eb));
      chk("cont_active", 32'(tx_active), 32'd1);
      chk("cont_pass_cnt", 32'(pass_cnt), 32'(passes % 16));
      chk("cont_done", 32'(done), 32'd0);
      if (c < n) @(negedge clk);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_tx_bit", 32'(tx_bit), 32'(IDLE_LVL));
    chk("abort_active", 32'(tx_active), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_pass_cnt", 32'(pass_cnt), 32'd4);
    #1 chk("abort_ready", 32'(start_ready), 32'd1);
    @(negedge clk);
    chk("abort_no_done_later", 32'(done), 32'd0);

    // Random transfers, some with illegal lengths, some with gated ena
    for (int t = 0; t < 14; t++) begin
      rl = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(17, 31)) * 5'($urandom_range(0, 1))
                                       : 5'($urandom_range(1, 16));
      xfer(16'($urandom), rl, 4'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset mid-pass
    @(negedge clk);
    pat_in = 16'b110; len_in = 5'd3; rep_in = 4'd1; start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    chk("rstmid_bit0", 32'(tx_bit), 32'd1);
    @(negedge clk);
    chk("rstmid_bit1", 32'(tx_bit), 32'd1);
    #2 rst_n = 1'b1;
    #1;
    chk("rstmid_tx_bit", 32'(tx_bit), 32'(IDLE_LVL));
    chk("rstmid_ready", 32'(start_ready), 32'd1);
    chk("rstmid_active", 32'(tx_active), 32'd0);
    chk("rstmid_done", 32'(done), 32'd0);
    chk("rstmid_pass_cnt", 32'(pass_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstmid_no_done", 32'(done), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
- Serial bit-pattern transmitter: the driving end of the single-bit serial line our sequence detector samples (detector input ui_in[0]).
- Loads a pattern of up to MAX_LEN bits and shifts it out MSB-first, one bit per enabled clock.
- Repeats the pattern a programmed number of times, with an idle gap between passes.
- Used on-chip as a self-test stimulus source and as a standalone pattern generator.

Parameters:
- MAX_LEN, 16, maximum pattern length in bits.
- CNT_W, 5, width of the length field; equals clog2(MAX_LEN+1).
- GAP, 2, idle cycles inserted between repeated passes; 0 means passes run back-to-back.
- IDLE_LEVEL, 0, level driven on tx_bit whenever no pattern bit is being sent.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous reset, active-HIGH despite the name: rst_n=1 resets immediately.
- ena  in  1  clock enable; registers update only on edges where ena=1.
- pat_in  in  MAX_LEN  pattern; only bits [len_in-1:0] are used.
- len_in  in  CNT_W  number of bits per pass; valid range 1..MAX_LEN.
- rep_in  in  4  number of passes; 0 means continuous until abort.
- start_valid  in  1  request to start a transfer.
- start_ready  out  1  transmitter can accept a start.
- abort  in  1  stop the current transfer.
- tx_bit  out  1  serial output, registered.
- tx_active  out  1  high while in SEND or GAP.
- done  out  1  end-of-transfer pulse.
- err  out  1  last accepted request had an illegal length.
- pass_cnt  out  4  completed passes in the current or last transfer.

Behaviour:
- Reset values: state=IDLE, tx_bit=IDLE_LEVEL, tx_active=0, done=0, err=0, pass_cnt=0, shift register=0, bit counter=0.
- Reset mid-transfer aborts the transfer immediately; no done pulse is produced.
- start_ready is combinational: start_ready = (state==IDLE) && ena && !abort.
- Accept occurs at an edge where start_valid && start_ready.
  - At that edge: pat_in, len_in and rep_in are latched.
  - pass_cnt clears to 0 and err is updated.
- Illegal length (len_in==0 or len_in>MAX_LEN):
  - Accept still occurs and err is set to 1.
  - State moves to DONE; tx_bit stays at IDLE_LEVEL and no bits are sent.
- Legal length: err clears to 0.
- States:
  - IDLE: tx_bit=IDLE_LEVEL. Goes to SEND on accept with a legal length.
  - SEND: tx_bit = latched pattern bit at index (len-1-k) for bit k of the pass; each bit is held for exactly one enabled cycle.
  - GAP: tx_bit=IDLE_LEVEL for GAP enabled cycles, then back to SEND starting again at bit len-1.
  - DONE: held for one enabled cycle with done=1, then to IDLE.
- Latency: the first pattern bit is visible on tx_bit in the cycle immediately after the accept edge.
  - One pass occupies len cycles in SEND.
- End of each pass (the edge that ends bit 0):
  - pass_cnt increments and wraps from 15 to 0 (continuous mode only).
  - If more passes remain (or rep=0): go to GAP, or directly back to SEND if GAP==0.
  - Otherwise go to DONE.
- tx_active=1 only in SEND and GAP. It is 0 in DONE, so the done cycle already shows tx_bit=IDLE_LEVEL.
- abort has priority over all transitions except reset:
  - At the next enabled edge in SEND, GAP or DONE, go to IDLE with tx_bit=IDLE_LEVEL and done=0.
  - pass_cnt holds its value; err is unchanged.
- abort and start_valid together in IDLE: start_ready=0, so the start is not accepted.
- ena=0: all registers, including done and tx_bit, hold their values. A done pulse therefore lasts until the next enabled edge.
- Changes to pat_in, len_in or rep_in after accept have no effect until the next accept.

Decomposition:
- Package seq_tx_pkg:
  - State enum: IDLE, SEND, GAP, DONE.
  - Length legality function: 1 <= len <= MAX_LEN.
  - Constant for the continuous-mode rep value (0).
- One sub-module, seq_bit_shifter:
  - Contains the loadable MAX_LEN shift register and the down-counting bit counter.
  - Inputs: load, shift, reload-from-latched-pattern.
  - Outputs: current bit, last_bit flag.
- seq_pattern_tx contains the FSM, gap counter, pass counter and the handshake.

Test Plan:
- pat=3'b100, len=3, rep=1, GAP=2, ena=1 → tx_bit 1,0,0 in the 3 cycles after accept; done=1 in the 4th cycle; pass_cnt=1; start_ready returns to 1 after done. Feeding tx_bit to the sequence detector gives one detection.
- pat=4'b1011, len=4, rep=2, GAP=2 → 1,0,1,1,0(gap),0(gap),1,0,1,1; then done pulse; pass_cnt=2; tx_active low only during the done cycle.
- len=0, start_valid=1 → err=1 and done pulse one cycle after accept; tx_bit constantly 0; tx_active never asserts. A following legal start clears err.
- rep=0, pat=2'b10, len=2, GAP=0 → continuous 1,0,1,0…; assert abort after 20 pass completions → tx_bit=0 and state IDLE after the next edge; no done pulse; pass_cnt=4 (20 mod 16).
- Toggle ena 1,0,0,1 mid-pass for pat=3'b110 → each bit is held for the 0-cycles and the bit sequence is unchanged. Assert rst_n=1 mid-pass → tx_bit=0 and start_ready=1 without waiting for a clock edge.
